// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host receiver with scancode FIFO
module ps2_rx #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        ren,
    output logic [15:0] data,
    output logic        ready,
    output logic        frame_err,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_data_sync;
    logic          r_clk_filt;
    logic [FW-1:0] r_filt_cnt;

    state_t        r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic          r_frame_err;
    logic [TW-1:0] r_to_cnt;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          r_overflow;

    logic w_clk_diff;
    logic w_filt_take;
    logic w_fall;
    logic w_bit;
    logic w_good;
    logic w_push;
    logic w_timeout;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr;

    // Two-stage synchronisers for both pins; idle bus level is high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
        end
    end

    // A level change is accepted on the FILTER_LEN-th consecutive differing sample
    assign w_clk_diff  = r_clk_sync[1] != r_clk_filt;
    assign w_filt_take = w_clk_diff && (r_filt_cnt == FW'(FILTER_LEN - 1));
    assign w_fall      = w_filt_take && r_clk_filt;
    assign w_bit       = r_data_sync[1];

    // Glitch filter on the synchronised PS/2 clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_filt <= 1'b1;
            r_filt_cnt <= '0;
        end else if (!w_clk_diff) begin
            r_filt_cnt <= '0;
        end else if (w_filt_take) begin
            r_clk_filt <= r_clk_sync[1];
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + FW'(1);
        end
    end

    // Odd parity: data bits plus parity bit must XOR to 1; stop bit must be 1
    assign w_good    = w_bit && (^{r_shift, r_parity});
    assign w_push    = (r_state == S_STOP) && w_fall && w_good;
    assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_to_cnt == TW'(TIMEOUT_CYCLES));

    // Frame deserialiser with mid-frame inactivity timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_parity    <= 1'b0;
            r_frame_err <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            r_frame_err <= 1'b0;
            if (r_state == S_IDLE || w_fall || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end

            if (w_timeout) begin
                r_frame_err <= 1'b1;
                r_state     <= S_IDLE;
            end else if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_bit) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        r_shift   <= {w_bit, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_parity <= w_bit;
                        r_state  <= S_STOP;
                    end
                    S_STOP: begin
                        if (!w_good) begin
                            r_frame_err <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Pointer MSB distinguishes full from empty when the index bits match
    assign w_empty = r_wptr == r_rptr;
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = ren && !w_empty;
    assign w_wr    = w_push && (!w_full || w_pop);

    // FIFO pointers and sticky overflow; a same-cycle pop frees room for the push
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (AW+1)'(1);
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care while pointers say empty
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= r_shift;
        end
    end

    assign ready     = !w_empty;
    assign data      = w_empty ? 16'h0000 : {8'h00, r_mem[r_rptr[AW-1:0]]};
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - directed self-checking bench for ps2_rx
module tb_ps2_rx;

    localparam int HALF = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        ren = 1'b0;
    logic [15:0] data;
    logic        ready;
    logic        frame_err;
    logic        overflow;

    int   n_checks = 0;
    int   n_fail = 0;
    int   fe_total = 0;
    int   fe_base;
    logic rb_before;
    logic rb_after;

    always #5 clk = ~clk;

    ps2_rx #(
        .FIFO_DEPTH(8),
        .FILTER_LEN(4),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .ren(ren),
        .data(data),
        .ready(ready),
        .frame_err(frame_err),
        .overflow(overflow)
    );

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_total++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic par, input logic stop);
        return {stop, par, b, 1'b0};
    endfunction

    // bits[0] goes on the wire first; the stop bit samples ready around its strobe
    task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch, input bit ren_at_stop);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            if (glitch) begin
                wait_clk(HALF/2); ps2_clk = 1'b0; wait_clk(1); ps2_clk = 1'b1; wait_clk(HALF/2 - 1);
            end else begin
                wait_clk(HALF);
            end
            ps2_clk = 1'b0;
            if (i == 10) begin
                wait_clk(5);
                rb_before = ready;
                if (ren_at_stop) ren = 1'b1;
                wait_clk(1);
                ren = 1'b0;
                rb_after = ready;
                wait_clk(HALF - 6);
            end else if (glitch) begin
                wait_clk(HALF/2); ps2_clk = 1'b1; wait_clk(1); ps2_clk = 1'b0; wait_clk(HALF/2 - 1);
            end else begin
                wait_clk(HALF);
            end
            ps2_clk = 1'b1;
        end
        wait_clk(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(mk_frame(b, ~^b, 1'b1), 11, 1'b0, 1'b0);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check_eq({tag, "_ready"}, {31'd0, ready}, 32'd1);
        check_eq({tag, "_data"}, {16'd0, data}, {24'd0, exp});
        ren = 1'b1;
        wait_clk(1);
        ren = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; ren = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(5);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check_eq("rst_ready", {31'd0, ready}, 32'd0);
        check_eq("rst_data", {16'd0, data}, 32'd0);
        check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check_eq("rst_overflow", {31'd0, overflow}, 32'd0);

        // 0x1C: three ones, odd-parity bit 0
        fe_base = fe_total;
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11, 1'b0, 1'b0);
        check_eq("1c_ready_before_push", {31'd0, rb_before}, 32'd0);
        check_eq("1c_ready_after_push", {31'd0, rb_after}, 32'd1);
        pop_check("1c", 8'h1C);
        check_eq("1c_empty_ready", {31'd0, ready}, 32'd0);
        check_eq("1c_empty_data", {16'd0, data}, 32'd0);
        check_eq("1c_no_err", fe_total - fe_base, 32'd0);

        // 0xF0 has four ones, so parity 0 is the wrong bit
        fe_base = fe_total;
        send_bits(mk_frame(8'hF0, 1'b0, 1'b1), 11, 1'b0, 1'b0);
        check_eq("parity_err_pulse", fe_total - fe_base, 32'd1);
        check_eq("parity_err_ready", {31'd0, ready}, 32'd0);

        fe_base = fe_total;
        send_bits(mk_frame(8'h33, 1'b1, 1'b0), 11, 1'b0, 1'b0);
        ps2_data = 1'b1;
        wait_clk(HALF);
        check_eq("stop_err_pulse", fe_total - fe_base, 32'd1);
        check_eq("stop_err_ready", {31'd0, ready}, 32'd0);

        ren = 1'b1; wait_clk(1); ren = 1'b0;
        send_byte(8'h44);
        pop_check("ren_empty", 8'h44);
        check_eq("ren_empty_after", {31'd0, ready}, 32'd0);

        // Nine bytes into an eight-entry FIFO
        for (int i = 1; i <= 9; i++) send_byte(8'(i));
        check_eq("ovf_set", {31'd0, overflow}, 32'd1);
        for (int i = 1; i <= 8; i++) pop_check("ovf_pop", 8'(i));
        check_eq("ovf_drained", {31'd0, ready}, 32'd0);
        check_eq("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Partial frame then silence
        do_reset();
        fe_base = fe_total;
        send_bits(mk_frame(8'h05, 1'b1, 1'b1), 4, 1'b0, 1'b0);
        check_eq("to_not_yet", fe_total - fe_base, 32'd0);
        wait_clk(1100);
        check_eq("to_pulse", fe_total - fe_base, 32'd1);
        check_eq("to_ready", {31'd0, ready}, 32'd0);
        send_byte(8'h5A);
        pop_check("after_to", 8'h5A);
        check_eq("after_to_err", fe_total - fe_base, 32'd1);

        // Full FIFO with a pop landing on the push cycle; write pointer wraps
        do_reset();
        for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i));
        send_bits(mk_frame(8'hAA, ~^8'hAA, 1'b1), 11, 1'b0, 1'b1);
        check_eq("full_ready_before", {31'd0, rb_before}, 32'd1);
        check_eq("full_no_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 1; i < 8; i++) pop_check("full_pop", 8'h11 + 8'(i));
        pop_check("full_last", 8'hAA);
        check_eq("full_drained", {31'd0, ready}, 32'd0);

        // Short glitches on ps2_clk
        fe_base = fe_total;
        send_bits(mk_frame(8'h29, ~^8'h29, 1'b1), 11, 1'b1, 1'b0);
        check_eq("glitch_err", fe_total - fe_base, 32'd0);
        check_eq("glitch_data", {16'd0, data}, 32'h29);

        // Asynchronous reset mid-frame with a byte still queued
        send_bits(mk_frame(8'h77, ~^8'h77, 1'b1), 3, 1'b0, 1'b0);
        check_eq("pre_rst_ready", {31'd0, ready}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("mid_rst_ready", {31'd0, ready}, 32'd0);
        check_eq("mid_rst_data", {16'd0, data}, 32'd0);
        check_eq("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
        check_eq("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        ps2_clk = 1'b1; ps2_data = 1'b1;
        wait_clk(2);
        reset = 1'b0;
        wait_clk(HALF);
        send_byte(8'h3C);
        pop_check("post_rst", 8'h3C);
        check_eq("post_rst_empty", {31'd0, ready}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
